// File: rtl/seg_seq_pkg.sv
// Shared types and segment encodings for the countdown/live segment sequencer.
// Bit order of every mask: bit0=a ... bit6=g, bit7=dp.
package seg_seq_pkg;

    typedef enum logic [1:0] {
        COUNTDOWN = 2'd0,
        BLINK     = 2'd1,
        LIVE      = 2'd2
    } seq_state_t;

    localparam logic [7:0] SEG_DIGIT_0 = 8'h3F;
    localparam logic [7:0] SEG_DIGIT_1 = 8'h06;
    localparam logic [7:0] SEG_DIGIT_2 = 8'h5B;
    localparam logic [7:0] SEG_DIGIT_3 = 8'h4F;
    localparam logic [7:0] SEG_DIGIT_4 = 8'h66;
    localparam logic [7:0] SEG_DIGIT_5 = 8'h6D;
    localparam logic [7:0] SEG_DIGIT_6 = 8'h7D;
    localparam logic [7:0] SEG_DIGIT_7 = 8'h07;
    localparam logic [7:0] SEG_DIGIT_8 = 8'h7F;
    localparam logic [7:0] SEG_DIGIT_9 = 8'h67;
    localparam logic [7:0] SEG_DP      = 8'h80;
    localparam logic [7:0] SEG_BLANK   = 8'h00;

    // Steps 0..9 count 9 down to 0, then dp/blank alternate for the tail.
    function automatic logic [7:0] countdown_seg(input logic [3:0] idx);
        logic [7:0] mask;
        case (idx)
            4'd0:    mask = SEG_DIGIT_9;
            4'd1:    mask = SEG_DIGIT_8;
            4'd2:    mask = SEG_DIGIT_7;
            4'd3:    mask = SEG_DIGIT_6;
            4'd4:    mask = SEG_DIGIT_5;
            4'd5:    mask = SEG_DIGIT_4;
            4'd6:    mask = SEG_DIGIT_3;
            4'd7:    mask = SEG_DIGIT_2;
            4'd8:    mask = SEG_DIGIT_1;
            4'd9:    mask = SEG_DIGIT_0;
            4'd10,
            4'd12,
            4'd14:   mask = SEG_DP;
            default: mask = SEG_BLANK;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/seg_sequencer_if.sv
// Frame strobe, switch inputs and renderer-facing outputs of the segment sequencer.
interface seg_sequencer_if;
    logic       frame_tick;
    logic [7:0] sw_in;
    logic [7:0] seg;
    logic       show;
    logic [6:0] anim_phase;
    logic [3:0] step;

    modport master (
        output frame_tick, sw_in,
        input  seg, show, anim_phase, step
    );

    modport slave (
        input  frame_tick, sw_in,
        output seg, show, anim_phase, step
    );
endinterface

// File: rtl/seg_sequencer_debounce.sv
// frame_debounce: switch synchronizer plus a stability counter that only advances
// on frame ticks, so a value is accepted after DEBOUNCE_FRAMES identical frame samples.
module frame_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [3:0] STAB_DONE = 4'(DEBOUNCE_FRAMES - 1);

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sw_s;
    logic [7:0] samp;
    logic [3:0] stab;
    logic [3:0] stab_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'h00;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sw_s = sync_q[SYNC_STAGES-1];

    // New sample matching the previous one extends the run; the run saturates at 15.
    always_comb begin
        stab_next = 4'd0;
        if (sw_s == samp) begin
            stab_next = (stab == 4'hF) ? stab : stab + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp <= 8'h00;
            stab <= 4'd0;
            dout <= 8'h00;
        end else if (frame_tick) begin
            samp <= sw_s;
            stab <= stab_next;
            if (stab_next >= STAB_DONE) dout <= sw_s;
        end
    end

endmodule

// File: rtl/seg_sequencer.sv
// seg_sequencer: frame-paced countdown animation that hands over to live switch display.
// Build option SEG_SEQ_LOOP_EN: countdown loops forever instead of ending in a dp blink.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  COUNTDOWN | seg follows the 16-step countdown table indexed by step
//  BLINK     | countdown finished; dp toggles every FRAMES_PER_STEP frames
//  LIVE      | seg mirrors debounced switches; held until reset
module seg_sequencer
    import seg_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int FRAMES_PER_STEP = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_sequencer_if.slave  bus
);

    localparam int STEP_LSB = $clog2(FRAMES_PER_STEP);
    // Widen past 10 bits only when a large step size would push the step field off the top.
    localparam int FCNT_W   = (STEP_LSB + 4 > 10) ? STEP_LSB + 4 : 10;

    logic [FCNT_W-1:0] fcnt;
    logic [FCNT_W-1:0] fcnt_next;
    logic [3:0]        step_next;
    logic [7:0]        sw_db;
    logic [7:0]        seg_q;
    logic              show_q;
    seq_state_t        state;

    frame_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (bus.frame_tick),
        .din        (bus.sw_in),
        .dout       (sw_db)
    );

    assign fcnt_next = fcnt + FCNT_W'(1);
    assign step_next = fcnt_next[STEP_LSB+3:STEP_LSB];

`ifdef SEG_SEQ_LOOP_EN
`else
    logic step_last;
    assign step_last = (fcnt[STEP_LSB+3:STEP_LSB] == 4'hF) && (&fcnt[STEP_LSB-1:0]);
`endif

    // sw_db here is the value from before this tick, so live entry lags the debouncer by one tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= COUNTDOWN;
            fcnt   <= '0;
            seg_q  <= SEG_DIGIT_9;
            show_q <= 1'b0;
        end else if (bus.frame_tick) begin
            fcnt <= fcnt_next;
            if (sw_db != 8'h00) begin
                state  <= LIVE;
                show_q <= 1'b1;
                seg_q  <= sw_db;
            end else begin
                case (state)
                    COUNTDOWN: begin
`ifdef SEG_SEQ_LOOP_EN
                        seg_q <= countdown_seg(step_next);
`else
                        if (step_last) begin
                            state <= BLINK;
                            seg_q <= fcnt_next[STEP_LSB] ? SEG_BLANK : SEG_DP;
                        end else begin
                            seg_q <= countdown_seg(step_next);
                        end
`endif
                    end
`ifdef SEG_SEQ_LOOP_EN
`else
                    BLINK: begin
                        seg_q <= fcnt_next[STEP_LSB] ? SEG_BLANK : SEG_DP;
                    end
`endif
                    LIVE: begin
                        seg_q <= sw_db;
                    end
                    default: begin
                        state <= COUNTDOWN;
                        seg_q <= countdown_seg(step_next);
                    end
                endcase
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.show       = show_q;
    assign bus.anim_phase = fcnt[6:0];
    assign bus.step       = fcnt[STEP_LSB+3:STEP_LSB];

endmodule

// File: tb/tb_seg_sequencer.sv
// Randomized bench for seg_sequencer against a frame-level reference model.
module tb_seg_sequencer;

    localparam int DB  = 4;
    localparam int FPS = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_sequencer_if bus ();

    seg_sequencer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_FRAMES (DB),
        .FRAMES_PER_STEP (FPS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] digit_tbl [16] = '{8'h67, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B,
                                   8'h06, 8'h3F, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80, 8'h00};

    // Reference model: counts frames since reset and keeps the recent frame samples.
    int         m_frames;
    logic [7:0] m_hist [$];
    logic [7:0] m_db;
    bit         m_live;
    logic [7:0] m_seg;

    function automatic logic [7:0] exp_countdown(input int frames);
`ifdef SEG_SEQ_LOOP_EN
        return digit_tbl[(frames / FPS) % 16];
`else
        if (frames < 16 * FPS) return digit_tbl[(frames / FPS) % 16];
        return (((frames / FPS) % 2) != 0) ? 8'h00 : 8'h80;
`endif
    endfunction

    function automatic logic [19:0] exp_vec();
        return {m_seg, m_live, 7'(m_frames % 128), 4'((m_frames / FPS) % 16)};
    endfunction

    task automatic model_reset();
        m_frames = 0;
        m_hist.delete();
        m_db   = 8'h00;
        m_live = 1'b0;
        m_seg  = 8'h67;
    endtask

    task automatic model_tick(input logic [7:0] samp);
        logic [7:0] db_before;
        bit         same;
        db_before = m_db;
        m_hist.push_back(samp);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        if (m_hist.size() == DB) begin
            same = 1'b1;
            foreach (m_hist[i]) if (m_hist[i] != samp) same = 1'b0;
            if (same) m_db = samp;
        end
        m_frames++;
        if (db_before != 8'h00) m_live = 1'b1;
        m_seg = m_live ? db_before : exp_countdown(m_frames);
    endtask

    task automatic pulse(input int gap);
        repeat (gap) @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        model_tick(bus.sw_in);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        bus.frame_tick = 1'b0;
        bus.sw_in      = 8'h00;
        do_reset();
        checks++;
        if (bus.seg !== 8'h67) begin errors++; $display("FAIL reset_seg: got %h exp 67", bus.seg); end
        checks++;
        if (bus.show !== 1'b0) begin errors++; $display("FAIL reset_show: got %b exp 0", bus.show); end
        checks++;
        if (bus.anim_phase !== 7'd0) begin errors++; $display("FAIL reset_phase: got %0d exp 0", bus.anim_phase); end
        checks++;
        if (bus.step !== 4'd0) begin errors++; $display("FAIL reset_step: got %0d exp 0", bus.step); end
    endtask

    task automatic test_countdown();
        bus.sw_in = 8'h00;
        for (int i = 0; i < 1100; i++) begin
            pulse(int'($urandom_range(3, 5)));
            checks++;
            if ({bus.seg, bus.show, bus.anim_phase, bus.step} !== exp_vec()) begin
                errors++;
                $display("FAIL countdown tick %0d: got %h exp %h", m_frames,
                         {bus.seg, bus.show, bus.anim_phase, bus.step}, exp_vec());
            end
            if (m_frames == 64) begin
                checks++;
                if (bus.seg !== 8'h7F || bus.step !== 4'd1) begin
                    errors++; $display("FAIL step1_digit8: got seg %h step %0d exp 7f 1", bus.seg, bus.step);
                end
            end
            if (m_frames == 128) begin
                checks++;
                if (bus.anim_phase !== 7'd0) begin
                    errors++; $display("FAIL phase_wrap: got %0d exp 0", bus.anim_phase);
                end
            end
            if (m_frames == 1024) begin
                checks++;
`ifdef SEG_SEQ_LOOP_EN
                if (bus.seg !== 8'h67) begin errors++; $display("FAIL loop_wrap: got %h exp 67", bus.seg); end
`else
                if (bus.seg !== 8'h80) begin errors++; $display("FAIL blink_start: got %h exp 80", bus.seg); end
`endif
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] g;
        int         len;
        do_reset();
        for (int i = 0; i < 100; i++) pulse(int'($urandom_range(3, 5)));
        g   = 8'($urandom_range(1, 255));
        len = int'($urandom_range(1, 3));
        bus.sw_in = g;
        for (int i = 0; i < len; i++) pulse(3);
        bus.sw_in = 8'h00;
        for (int i = 0; i < 6; i++) begin
            pulse(int'($urandom_range(3, 5)));
            checks++;
            if ({bus.seg, bus.show, bus.anim_phase, bus.step} !== exp_vec()) begin
                errors++;
                $display("FAIL glitch tick %0d: got %h exp %h", m_frames,
                         {bus.seg, bus.show, bus.anim_phase, bus.step}, exp_vec());
            end
        end
        checks++;
        if (bus.show !== 1'b0) begin errors++; $display("FAIL glitch_show: got %b exp 0 (len %0d)", bus.show, len); end
    endtask

    task automatic test_live_entry();
        logic [7:0] v;
        v = 8'($urandom_range(1, 255));
        for (int i = 0; i < 200 && m_frames < 123; i++) pulse(3);
        bus.sw_in = v;
        for (int i = 0; i < 10; i++) begin
            pulse(int'($urandom_range(3, 5)));
            checks++;
            if ({bus.seg, bus.show, bus.anim_phase, bus.step} !== exp_vec()) begin
                errors++;
                $display("FAIL live_entry tick %0d: got %h exp %h", m_frames,
                         {bus.seg, bus.show, bus.anim_phase, bus.step}, exp_vec());
            end
            if (m_frames == 127) begin
                checks++;
                if (bus.show !== 1'b0) begin errors++; $display("FAIL live_early: got show %b exp 0", bus.show); end
            end
            if (m_frames == 128) begin
                checks++;
                if (bus.seg !== v || bus.show !== 1'b1) begin
                    errors++; $display("FAIL live_wins_boundary: got seg %h show %b exp %h 1", bus.seg, bus.show, v);
                end
            end
        end
    endtask

    task automatic test_live_drop();
        bus.sw_in = 8'h00;
        for (int i = 0; i < 200; i++) begin
            pulse(int'($urandom_range(3, 5)));
            checks++;
            if ({bus.seg, bus.show, bus.anim_phase, bus.step} !== exp_vec()) begin
                errors++;
                $display("FAIL live_drop tick %0d: got %h exp %h", m_frames,
                         {bus.seg, bus.show, bus.anim_phase, bus.step}, exp_vec());
            end
        end
        checks++;
        if (bus.seg !== 8'h00 || bus.show !== 1'b1) begin
            errors++; $display("FAIL live_sticky: got seg %h show %b exp 00 1", bus.seg, bus.show);
        end
    endtask

    task automatic test_hold_between_ticks();
        logic [7:0] v;
        v = 8'($urandom_range(1, 255));
        bus.sw_in = v;
        for (int i = 0; i < 6; i++) pulse(3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.sw_in = 8'($urandom);
            checks++;
            if (bus.seg !== m_seg) begin
                errors++; $display("FAIL hold_between_ticks clk %0d: got %h exp %h", i, bus.seg, m_seg);
            end
        end
        bus.sw_in = v;
        pulse(3);
        checks++;
        if ({bus.seg, bus.show, bus.anim_phase, bus.step} !== exp_vec()) begin
            errors++;
            $display("FAIL hold_next_tick: got %h exp %h", {bus.seg, bus.show, bus.anim_phase, bus.step}, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        bus.sw_in = 8'h00;
        do_reset();
        pulse(3);
        for (int i = 0; i < 70; i++) begin
            pulse(0);
            checks++;
            if ({bus.seg, bus.show, bus.anim_phase, bus.step} !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_count tick %0d: got %h exp %h", m_frames,
                         {bus.seg, bus.show, bus.anim_phase, bus.step}, exp_vec());
            end
        end
        bus.sw_in = 8'hAA;
        pulse(3);
        for (int i = 0; i < 6; i++) begin
            pulse(0);
            checks++;
            if ({bus.seg, bus.show, bus.anim_phase, bus.step} !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_live tick %0d: got %h exp %h", m_frames,
                         {bus.seg, bus.show, bus.anim_phase, bus.step}, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        bus.sw_in = 8'hFF;
        do_reset();
        for (int i = 0; i < 2; i++) pulse(3);
        do_reset();
        checks++;
        if ({bus.seg, bus.show, bus.anim_phase, bus.step} !== {8'h67, 1'b0, 7'd0, 4'd0}) begin
            errors++;
            $display("FAIL midreset_outputs: got %h exp %h", {bus.seg, bus.show, bus.anim_phase, bus.step},
                     {8'h67, 1'b0, 7'd0, 4'd0});
        end
        for (int i = 0; i < 6; i++) begin
            pulse(int'($urandom_range(3, 5)));
            checks++;
            if ({bus.seg, bus.show, bus.anim_phase, bus.step} !== exp_vec()) begin
                errors++;
                $display("FAIL midreset_tick %0d: got %h exp %h", m_frames,
                         {bus.seg, bus.show, bus.anim_phase, bus.step}, exp_vec());
            end
            if (m_frames == 4) begin
                checks++;
                if (bus.show !== 1'b0) begin errors++; $display("FAIL midreset_restart: got show %b exp 0", bus.show); end
            end
            if (m_frames == 5) begin
                checks++;
                if (bus.show !== 1'b1 || bus.seg !== 8'hFF) begin
                    errors++; $display("FAIL midreset_live: got seg %h show %b exp ff 1", bus.seg, bus.show);
                end
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.sw_in      = 8'h00;
        model_reset();
        test_reset();
        test_countdown();
        test_glitch();
        test_live_entry();
        test_live_drop();
        test_hold_between_ticks();
        test_back_to_back();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
